// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_pkg
// Description : AXI response codes, line-fill FSM encoding and the word-index
//               helper shared by the line return buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } fill_state_t;

    // Wrap-burst word position: start word plus beat number, modulo words per line.
    function automatic int unsigned line_word_idx(input int unsigned start,
                                                  input int unsigned beat,
                                                  input int unsigned offset_width);
        return (start + beat) & ((32'd1 << offset_width) - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : line_req_fifo
// Description : Small synchronous FIFO holding the first-word index of each
//               outstanding line request.
// Revision    : 1.0 - initial release
// ============================================================================
module line_req_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_line_return_buffer.sv
`default_nettype none
// ============================================================================
// Module      : axi_line_return_buffer
// Description : Assembles AXI R beats (wrap, critical word first) into cache
//               lines, forwards the critical word and queues finished lines.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_line_return_buffer
    import axi_pkg::*;
#(
    parameter int OFFSET_WIDTH = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_ENTRIES  = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    req_valid,
    output logic                                    req_ready,
    input  logic [OFFSET_WIDTH-1:0]                 req_word,
    input  logic                                    rvalid,
    output logic                                    rready,
    input  logic [DATA_WIDTH-1:0]                   rdata,
    input  logic [1:0]                              rresp,
    input  logic                                    rlast,
    output logic                                    crit_valid,
    output logic [DATA_WIDTH-1:0]                   crit_data,
    output logic                                    line_valid,
    input  logic                                    line_ready,
    output logic [(1<<OFFSET_WIDTH)*DATA_WIDTH-1:0] line_data,
    output logic                                    line_err
);

    localparam int c_WORDS = 1 << OFFSET_WIDTH;
    localparam int c_PTR_W = $clog2(NUM_ENTRIES);
    localparam int c_CNT_W = $clog2(NUM_ENTRIES + 1);

    fill_state_t                          r_state;
    logic [c_PTR_W-1:0]                   r_wr_ptr;
    logic [c_PTR_W-1:0]                   r_rd_ptr;
    logic [c_CNT_W-1:0]                   r_outstanding;
    logic [OFFSET_WIDTH-1:0]              r_start;
    logic [OFFSET_WIDTH-1:0]              r_beat;
    logic                                 r_err;
    logic [NUM_ENTRIES-1:0]               r_slot_full;
    logic [NUM_ENTRIES-1:0]               r_slot_err;
    logic [c_WORDS-1:0][DATA_WIDTH-1:0]   r_slot_data [NUM_ENTRIES];
    logic                                 r_crit_valid;
    logic [DATA_WIDTH-1:0]                r_crit_data;

    logic                    w_req_push;
    logic                    w_line_pop;
    logic                    w_beat_acc;
    logic                    w_last_beat;
    logic                    w_err_next;
    logic                    w_complete;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [OFFSET_WIDTH-1:0] w_fifo_head;
    logic [OFFSET_WIDTH-1:0] w_word_idx;

    assign req_ready   = (r_outstanding < c_CNT_W'(NUM_ENTRIES)) && !w_fifo_full;
    assign rready      = (r_state == ST_FILL) || (r_state == ST_DRAIN);
    assign w_req_push  = req_valid && req_ready;
    assign w_beat_acc  = rvalid && rready;
    assign line_valid  = r_slot_full[r_rd_ptr];
    assign line_data   = r_slot_data[r_rd_ptr];
    assign line_err    = r_slot_err[r_rd_ptr];
    assign w_line_pop  = line_valid && line_ready;
    assign crit_valid  = r_crit_valid;
    assign crit_data   = r_crit_data;

    assign w_last_beat = &r_beat;
    assign w_err_next  = r_err || (rresp != RESP_OKAY);
    assign w_complete  = (r_state == ST_FILL) && w_beat_acc && (rlast || w_last_beat);
    assign w_word_idx  = OFFSET_WIDTH'(line_word_idx(32'(r_start), 32'(r_beat),
                                                     32'(OFFSET_WIDTH)));

    line_req_fifo #(
        .WIDTH (OFFSET_WIDTH),
        .DEPTH (NUM_ENTRIES)
    ) u_req_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_req_push),
        .i_push_data (req_word),
        .i_pop       (w_complete),
        .o_head      (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
        end else begin
            case ({w_req_push, w_line_pop})
                2'b10:   r_outstanding <= r_outstanding + c_CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - c_CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // The slot being filled is never full, so a pop at rd_ptr cannot collide with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_start      <= '0;
            r_beat       <= '0;
            r_err        <= 1'b0;
            r_slot_full  <= '0;
            r_slot_err   <= '0;
            r_crit_valid <= 1'b0;
            r_crit_data  <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_slot_data[i] <= '0;
            end
        end else begin
            r_crit_valid <= 1'b0;

            if (w_line_pop) begin
                r_slot_full[r_rd_ptr] <= 1'b0;
                r_slot_err[r_rd_ptr]  <= 1'b0;
                r_slot_data[r_rd_ptr] <= '0;
                r_rd_ptr              <= r_rd_ptr + c_PTR_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty && !r_slot_full[r_wr_ptr]) begin
                        r_state               <= ST_FILL;
                        r_start               <= w_fifo_head;
                        r_beat                <= '0;
                        r_err                 <= 1'b0;
                        r_slot_data[r_wr_ptr] <= '0;
                        r_slot_err[r_wr_ptr]  <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (w_beat_acc) begin
                        r_slot_data[r_wr_ptr][w_word_idx] <= rdata;
                        r_beat <= r_beat + OFFSET_WIDTH'(1);
                        r_err  <= w_err_next;
                        if (r_beat == '0) begin
                            r_crit_data  <= rdata;
                            r_crit_valid <= 1'b1;
                        end
                        // rlast on any beat but the last, or missing on the last, is a count error.
                        if (w_complete) begin
                            r_slot_full[r_wr_ptr] <= 1'b1;
                            r_slot_err[r_wr_ptr]  <= w_err_next || (rlast != w_last_beat);
                            r_wr_ptr              <= r_wr_ptr + c_PTR_W'(1);
                            r_state               <= (w_last_beat && !rlast) ? ST_DRAIN : ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_beat_acc && rlast) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
